data_mem_sized: RTL

DATA_MEM_SIZED -- requirements
Module: data_mem_sized

---
 rtl/data_mem_sized_if.sv | 31 +++
 rtl/data_mem_sized.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/data_mem_sized_if.sv
// Purpose : request/response bundle for data_mem_sized (sized load/store port plus debug read).
// Latency : carries no state of its own; timing is set by the memory behind the slave modport.
// Backpr. : master may only present a request while ready=1; requests seen with ready=0 are dropped.
// Signals (master -> slave): req_valid, req_write, req_size, req_unsigned, req_addr, wr_data, dbg_addr
// Signals (slave -> master): rd_data, rd_valid, err_misaligned, ready, dbg_data
interface data_mem_sized_if #(
  parameter int RAM_ADDR_BITS = 10
);
  logic                     req_valid;
  logic                     req_write;
  logic [1:0]               req_size;
  logic                     req_unsigned;
  logic [RAM_ADDR_BITS+1:0] req_addr;
  logic [31:0]              wr_data;
  logic [31:0]              rd_data;
  logic                     rd_valid;
  logic                     err_misaligned;
  logic                     ready;
  logic [RAM_ADDR_BITS-1:0] dbg_addr;
  logic [31:0]              dbg_data;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, wr_data, dbg_addr,
    input  rd_data, rd_valid, err_misaligned, ready, dbg_data
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, wr_data, dbg_addr,
    output rd_data, rd_valid, err_misaligned, ready, dbg_data
  );
endinterface

// File: rtl/data_mem_sized.sv
// Purpose : 32-bit word RAM with byte/half/word little-endian loads and stores, optional clear after reset.
// Latency : load result and debug read registered at the accepting negedge (one edge, no pipeline).
// Backpr. : ready=0 for the 2**RAM_ADDR_BITS clear cycles after reset; requests then are ignored.
// Ports   : i_clk (all state on negedge), i_rst_n (synchronous, active low, sampled on negedge),
//           io_mem (slave side of data_mem_sized_if: request, load result, error pulse, ready, debug read).
module data_mem_sized #(
  parameter int RAM_ADDR_BITS  = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  data_mem_sized_if.slave        io_mem
);
  localparam int DEPTH = 2 ** RAM_ADDR_BITS;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [RAM_ADDR_BITS-1:0] r_clr_cnt;
  logic [31:0]              r_ram [DEPTH];
  logic [31:0]              r_rd_data;
  logic                     r_rd_valid;
  logic                     r_err;
  logic [31:0]              r_dbg_data;

  logic                     w_ready;
  logic                     w_accept;
  logic                     w_misaligned;
  logic [RAM_ADDR_BITS-1:0] w_word;
  logic [1:0]               w_off;
  logic [3:0]               w_st_be;
  logic [31:0]              w_st_dat;
  logic                     w_ram_we;
  logic [RAM_ADDR_BITS-1:0] w_ram_waddr;
  logic [3:0]               w_ram_be;
  logic [31:0]              w_ram_wdat;
  logic [31:0]              w_rword;
  logic [31:0]              w_shift;
  logic [31:0]              w_load_val;

  // ---------------- FSM ----------------
  always_ff @(negedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: if (r_clr_cnt == {RAM_ADDR_BITS{1'b1}}) w_state_nxt = ST_IDLE;
      ST_IDLE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_ready = (r_state == ST_IDLE);

  // ---------------- request decode ----------------
  assign w_word   = io_mem.req_addr[RAM_ADDR_BITS+1:2];
  assign w_off    = io_mem.req_addr[1:0];
  assign w_accept = io_mem.req_valid & w_ready;

  always_comb begin
    w_misaligned = 1'b0;
    case (io_mem.req_size)
      2'b00:   w_misaligned = 1'b0;
      2'b01:   w_misaligned = w_off[0];
      2'b10:   w_misaligned = (w_off != 2'b00);
      default: w_misaligned = 1'b1;
    endcase
  end

  // Store data is replicated across lanes so the byte-enable alone picks the destination lane.
  always_comb begin
    w_st_be  = 4'b1111;
    w_st_dat = io_mem.wr_data;
    case (io_mem.req_size)
      2'b00: begin
        w_st_be  = 4'b0001 << w_off;
        w_st_dat = {4{io_mem.wr_data[7:0]}};
      end
      2'b01: begin
        w_st_be  = w_off[1] ? 4'b1100 : 4'b0011;
        w_st_dat = {2{io_mem.wr_data[15:0]}};
      end
      default: begin
        w_st_be  = 4'b1111;
        w_st_dat = io_mem.wr_data;
      end
    endcase
  end

  // Single write port shared by the clear sweep and accepted stores; reset suppresses both.
  always_comb begin
    w_ram_we    = 1'b0;
    w_ram_waddr = w_word;
    w_ram_be    = 4'b0000;
    w_ram_wdat  = 32'h0;
    if (i_rst_n) begin
      if (r_state == ST_CLEAR) begin
        w_ram_we    = 1'b1;
        w_ram_waddr = r_clr_cnt;
        w_ram_be    = 4'b1111;
      end else if (w_accept && io_mem.req_write && !w_misaligned) begin
        w_ram_we    = 1'b1;
        w_ram_be    = w_st_be;
        w_ram_wdat  = w_st_dat;
      end
    end
  end

  // Load path: shift the addressed lanes down to bit 0, then extend.
  assign w_rword = r_ram[w_word];
  assign w_shift = w_rword >> {w_off, 3'b000};

  always_comb begin
    w_load_val = w_rword;
    case (io_mem.req_size)
      2'b00:   w_load_val = {{24{~io_mem.req_unsigned & w_shift[7]}},  w_shift[7:0]};
      2'b01:   w_load_val = {{16{~io_mem.req_unsigned & w_shift[15]}}, w_shift[15:0]};
      default: w_load_val = w_rword;
    endcase
  end

  // ---------------- storage ----------------
  always_ff @(negedge i_clk) begin
    if (w_ram_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_ram_be[k]) r_ram[w_ram_waddr][8*k +: 8] <= w_ram_wdat[8*k +: 8];
      end
    end
  end

  always_ff @(negedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data  <= 32'h0;
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      r_dbg_data <= 32'h0;
      r_clr_cnt  <= '0;
    end else begin
      // Debug read samples the array before this edge's write lands.
      r_dbg_data <= r_ram[io_mem.dbg_addr];
      r_rd_valid <= 1'b0;
      r_err      <= 1'b0;
      if (r_state == ST_CLEAR) r_clr_cnt <= r_clr_cnt + 1'b1;
      if (w_accept) begin
        if (w_misaligned) begin
          r_err <= 1'b1;
        end else if (!io_mem.req_write) begin
          r_rd_data  <= w_load_val;
          r_rd_valid <= 1'b1;
        end
      end
    end
  end

  assign io_mem.ready          = w_ready;
  assign io_mem.rd_data        = r_rd_data;
  assign io_mem.rd_valid       = r_rd_valid;
  assign io_mem.err_misaligned = r_err;
  assign io_mem.dbg_data       = r_dbg_data;
endmodule
